// File: rtl/digit_scan.sv
// Six-digit multiplexed display scanner: one digit per SCAN_DIV clocks, a blank cycle on every
// digit change, frame-latched digit data. Optional build macro: LEAD_ZERO_BLANK_EN.
`timescale 1ns/1ps
module digit_scan #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] digits_i,
  output logic [3:0]  count,
  output logic [5:0]  dig_en,
  output logic        frame_o
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [2:0]  IDX_LAST = 3'd5;

  logic [15:0] pre_cnt_q, pre_cnt_d;
  logic [2:0]  idx_q, idx_d, idx_nx;
  logic [23:0] shadow_q, shadow_d;
  logic [3:0]  count_q, count_d, nib;
  logic [5:0]  dig_en_q, dig_en_d;
  logic        frame_q, frame_d;
  logic        tick, wrap;

  always_comb begin
    tick   = (pre_cnt_q == DIV_LAST);
    // Indices 6..7 are unreachable but fold back to 0 like a normal wrap.
    wrap   = (idx_q >= IDX_LAST);
    idx_nx = wrap ? 3'd0 : idx_q + 3'd1;

    // The new frame's digit 0 bypasses the shadow, which loads on this same edge.
    nib = 4'h0;
    case (idx_nx)
      3'd0:    nib = digits_i[3:0];
      3'd1:    nib = shadow_q[7:4];
      3'd2:    nib = shadow_q[11:8];
      3'd3:    nib = shadow_q[15:12];
      3'd4:    nib = shadow_q[19:16];
      3'd5:    nib = shadow_q[23:20];
      default: nib = 4'h0;
    endcase
`ifdef LEAD_ZERO_BLANK_EN
    if (idx_nx == IDX_LAST && nib == 4'h0) nib = 4'hF;
`endif

    pre_cnt_d = tick ? 16'd0 : pre_cnt_q + 16'd1;
    idx_d     = tick ? idx_nx : idx_q;
    shadow_d  = (tick && idx_q == IDX_LAST) ? digits_i : shadow_q;
    count_d   = tick ? nib : count_q;
    // Blanking on the change edge; afterwards the enable trails count by one cycle.
    dig_en_d  = tick ? 6'h3F : ~(6'd1 << idx_q);
    frame_d   = tick && (idx_q == IDX_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= 16'd0;
      idx_q     <= 3'd0;
      shadow_q  <= 24'd0;
      count_q   <= 4'h0;
      dig_en_q  <= 6'h3F;
      frame_q   <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      count_q   <= count_d;
      dig_en_q  <= dig_en_d;
      frame_q   <= frame_d;
    end
  end

  assign count   = count_q;
  assign dig_en  = dig_en_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_digit_scan.sv
// Bench for digit_scan (SCAN_DIV=4): reset checks, vector table, hand sequences, random digits
// against a cycle-count reference model. Define LEAD_ZERO_BLANK_EN to match the RTL build.
`timescale 1ns/1ps
module tb_digit_scan;

  localparam int D = 4;
`ifdef LEAD_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] digits_i = 24'h0;
  logic [3:0]  count;
  logic [5:0]  dig_en;
  logic        frame_o;

  digit_scan #(.SCAN_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .digits_i(digits_i),
    .count(count), .dig_en(dig_en), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          t = 0;          // edges since reset release
  logic [23:0] frame_m = 24'h0; // digits latched for the frame being shown
  logic [3:0]  prev_count;

  typedef struct {
    logic [23:0] digits;
    int          pos;
    logic [3:0]  exp;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
    end
  endtask

  // Displayed value for digit i of the latched frame.
  function automatic logic [3:0] disp_nib(input int i);
    logic [3:0] n;
    n = frame_m[4*i +: 4];
    if (LZB && i == 5 && n == 4'h0) n = 4'hF;
    return n;
  endfunction

  function automatic logic [3:0] exp_count();
    int k;
    k = t / D;
    if (k == 0) return 4'h0;
    return disp_nib(k % 6);
  endfunction

  function automatic logic [5:0] exp_en();
    logic [5:0] one;
    if (t == 0 || t % D == 0) return 6'h3F;
    one = 6'd1 << ((t / D) % 6);
    return ~one;
  endfunction

  task automatic step();
    int n;
    prev_count = count;
    @(posedge clk);
    t++;
    if (t % (6 * D) == 0) frame_m = digits_i;
    #1;
    check("count", {20'h0, count}, {20'h0, exp_count()});
    check("dig_en", {18'h0, dig_en}, {18'h0, exp_en()});
    check("frame_o", {23'h0, frame_o}, {23'h0, (t % (6 * D) == 0)});
    if (dig_en != 6'h3F) begin
      n = 0;
      for (int b = 0; b < 6; b++) if (!dig_en[b]) n = b;
      check("align", {20'h0, prev_count}, {20'h0, disp_nib(n)});
    end
  endtask

  // Step until just after the tick edge that moves the scan onto digit target.
  task automatic run_to_idx(input int target);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 6 * D + 2 && !hit; i++) begin
      step();
      if (t % D == 0 && (t / D) % 6 == target) hit = 1'b1;
    end
    check("idx_timeout", {23'h0, hit}, 24'h1);
  endtask

  logic [3:0] seq026[9];

  initial begin
    vecs[0] = '{24'h123456, 0, 4'h6};
    vecs[1] = '{24'h123456, 5, 4'h1};
    vecs[2] = '{24'h654321, 0, 4'h1};
    vecs[3] = '{24'h654321, 3, 4'h4};
    vecs[4] = '{24'h012345, 5, LZB ? 4'hF : 4'h0};
    vecs[5] = '{24'h112345, 5, 4'h1};
    vecs[6] = '{24'hABCDEF, 0, 4'hF};
    vecs[7] = '{24'hABCDEF, 4, 4'hB};
    vecs[8] = '{24'h000000, 5, LZB ? 4'hF : 4'h0};
    vecs[9] = '{24'h9A0000, 5, 4'h9};
    seq026 = '{4'h3, 4'h2, 4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};

    // Reset held
    digits_i = 24'h123456;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", {20'h0, count}, 24'h0);
    check("rst_dig_en", {18'h0, dig_en}, 24'h3F);
    check("rst_frame", {23'h0, frame_o}, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    frame_m = 24'h0;
    step();
    check("first_en", {18'h0, dig_en}, 24'h3E);

    // Two steady frames of 123456, with frame pulse shape
    run_to_idx(0);
    check("frame_pulse", {23'h0, frame_o}, 24'h1);
    check("frame0_count", {20'h0, count}, 24'h6);
    step();
    check("frame_pulse_end", {23'h0, frame_o}, 24'h0);
    for (int f = 0; f < 2 * 6 * D; f++) step();

    // Mid-frame change at digit 2 stays hidden until the next frame
    run_to_idx(0);
    run_to_idx(2);
    check("mid_idx2", {20'h0, count}, 24'h4);
    digits_i = 24'h654321;
    for (int i = 0; i < 9; i++) begin
      run_to_idx((3 + i) % 6);
      check("mid_change", {20'h0, count}, {20'h0, seq026[i]});
    end

    // Vector table
    foreach (vecs[v]) begin
      digits_i = vecs[v].digits;
      run_to_idx(0);
      if (vecs[v].pos != 0) run_to_idx(vecs[v].pos);
      check("vec", {20'h0, count}, {20'h0, vecs[v].exp});
    end

    // Asynchronous reset pulse between edges while on digit 3
    digits_i = 24'h123456;
    run_to_idx(0);
    run_to_idx(3);
    #2 rst_n = 1'b0;
    #1;
    check("async_count", {20'h0, count}, 24'h0);
    check("async_dig_en", {18'h0, dig_en}, 24'h3F);
    check("async_frame", {23'h0, frame_o}, 24'h0);
    #2 rst_n = 1'b1;
    t = 0;
    frame_m = 24'h0;
    step();
    check("restart_en", {18'h0, dig_en}, 24'h3E);
    run_to_idx(0);
    check("restart_frame", {20'h0, count}, 24'h6);

    // Random digit changes at random times
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15, 0) == 0) digits_i = 24'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/digit_scan.md
DIGIT_SCAN -- requirements
Module: digit_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles each digit is displayed; legal range 2..65535.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 digits_i  input  24  six BCD digits: [3:0]=digit 0 (seconds units) ... [23:20]=digit 5 (hours tens).
REQ-005 count  output  4  registered BCD nibble for the downstream seven-segment decoder.
REQ-006 dig_en  output  6  registered digit enables, active-low, bit n drives digit n.
REQ-007 frame_o  output  1  one-cycle pulse marking the start of a new scan frame.

Function
REQ-008 Prescaler pre_cnt (16 bit) SHALL count 0..SCAN_DIV-1 and wrap to 0; tick = (pre_cnt == SCAN_DIV-1).
REQ-009 Digit index idx (3 bit) SHALL advance on tick: 0->1->2->3->4->5->0; values 6..7 never reachable and SHALL recover to 0 on the next tick.
REQ-010 Shadow register SHALL hold the frame's digits; on a tick with idx==5 it SHALL load digits_i, otherwise it SHALL hold.
REQ-011 digits_i changes during a frame SHALL NOT affect count until the next frame load.
REQ-012 On a tick edge, count SHALL load the nibble for the new idx; at the wrap to idx 0 the nibble SHALL come from digits_i[3:0] directly (same edge as the shadow load).
REQ-013 On a tick edge, dig_en SHALL load 6'b111111 (one-cycle blanking gap, anti-ghosting).
REQ-014 On every non-tick edge, dig_en SHALL load ~(1<<idx), exactly one bit low.
REQ-015 dig_en therefore lags count by one cycle, matching the decoder's one-cycle registered latency; segment data and enable SHALL be aligned at the display pins.
REQ-016 frame_o SHALL be 1 for exactly the one cycle following the tick edge that wraps idx 5->0, otherwise 0.
REQ-017 Per digit period: 1 blank cycle + SCAN_DIV-1 enabled cycles; frame period = 6*SCAN_DIV cycles.
REQ-018 Non-BCD nibbles (A..F) in digits_i SHALL pass to count unchanged; the decoder blanks them.

Reset
REQ-019 While rst_n==0, asynchronously: pre_cnt=0, idx=0, shadow=0, count=4'h0, dig_en=6'b111111, frame_o=0.
REQ-020 First edge after release SHALL set dig_en=6'b111110 (digit 0 showing shadow value 0); first frame load occurs at the first tick with idx==5.
REQ-021 Reset asserted mid-frame SHALL take effect immediately without a clock edge and discard the in-progress frame.

Configuration
REQ-022 Macro LEAD_ZERO_BLANK_EN: when defined, if the digit-5 nibble is 4'h0 then count SHALL be 4'hF while idx==5 (decoder blanks it); dig_en timing unchanged.
REQ-023 Without LEAD_ZERO_BLANK_EN, digit 5 SHALL display its nibble unmodified, including 0.

Verification (SCAN_DIV=4)
REQ-024 Hold rst_n=0 -> count=0, dig_en=6'h3F, frame_o=0; release -> next edge dig_en=6'h3E.
REQ-025 digits_i=24'h123456 steady, two frames -> count sequence 6,5,4,3,2,1 repeating, each held 4 cycles; dig_en 3F for 1 cycle then 3E/3D/3B/37/2F/1F for 3 cycles each; frame_o pulses every 24 cycles.
REQ-026 Change digits_i from 24'h123456 to 24'h654321 while idx==2 -> remaining digits of frame still show 3,2,1; next frame shows 1,2,3,4,5,6.
REQ-027 Check count vs dig_en alignment: at each edge where dig_en shows digit n enabled, the value count held during the previous cycle equals nibble n (the value the decoder has just registered).
REQ-028 digits_i=24'h012345: with LEAD_ZERO_BLANK_EN, count=4'hF during idx 5; without it, count=4'h0; digits_i=24'h112345 -> count=4'h1 in both builds.
REQ-029 Pulse rst_n low for 3 ns between clock edges while idx==3 -> outputs reach reset values immediately; scan restarts at digit 0.
